// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma plugboard programming path.
//
// Contents:
//   NUM_LETTERS        alphabet width; every letter bus is one-hot of this width
//   DEFAULT_MAX_PAIRS  default number of plug cables held in the table
//   ERR_*              error codes reported on err_code
//   state_e            plug_pair_writer controller states
package enigma_pkg;

    localparam int unsigned NUM_LETTERS       = 26;
    localparam int unsigned DEFAULT_MAX_PAIRS = 10;

    localparam logic [1:0] ERR_SELF   = 2'd0;  // second letter equals the first
    localparam logic [1:0] ERR_USED   = 2'd1;  // letter already plugged
    localparam logic [1:0] ERR_FULL   = 2'd2;  // no free cable left
    localparam logic [1:0] ERR_ONEHOT = 2'd3;  // letter code not exactly one bit

    typedef enum logic [2:0] {
        StIdle,
        StHold,
        StWrite,
        StWriteRev,
        StClear
    } state_e;

endpackage

// File: rtl/plug_pair_writer_if.sv
// Write port from the pair writer into the plugboard lookup table.
//
// Signals:
//   wr_valid  write request (held until accepted)
//   wr_a      one-hot source letter of the pair
//   wr_b      one-hot partner letter of the pair
//   wr_ready  table accepts the write when high together with wr_valid
// Modports:
//   master    pair writer side
//   slave     plugboard table side
interface plug_pair_writer_if #(
    parameter int unsigned LETTERS = enigma_pkg::NUM_LETTERS
);

    logic               wr_valid;
    logic [LETTERS-1:0] wr_a;
    logic [LETTERS-1:0] wr_b;
    logic               wr_ready;

    modport master (
        output wr_valid,
        output wr_a,
        output wr_b,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_a,
        input  wr_b,
        output wr_ready
    );

endinterface

// File: rtl/onehot_check.sv
// Combinational exactly-one-bit-set test.
//
// Ports:
//   vec_i     vector under test
//   onehot_o  high when exactly one bit of vec_i is set
module onehot_check #(
    parameter int unsigned WIDTH = 26
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             onehot_o
);

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    always_comb begin
        onehot_o = (vec_i != '0) && ((vec_i & (vec_i - WIDTH'(1))) == '0);
    end

endmodule

// File: rtl/plug_pair_writer.sv
// Plugboard programming front end: collects one-hot letter strobes into pairs, rejects illegal
// pairs and writes each legal pair into the plugboard table over a valid/ready port.
//
// Optional feature: define PLUG_RECIPROCAL_EN to issue a second, reversed write (B->A) after
// every forward write; used/pair_count then update only once both writes are accepted.
//
// Ports:
//   CLOCK_50      system clock
//   reset         asynchronous active-low reset
//   letter_in     one-hot letter code, bit 0 = A
//   letter_valid  single-cycle strobe qualifying letter_in
//   clear         single-cycle request to remove all pairs
//   wr            write port to the plugboard table (master side)
//   table_clear   one-cycle pulse ordering the table to empty itself
//   used          mask of letters currently plugged
//   pair_count    number of committed pairs
//   busy          high in every state other than idle
//   err           one-cycle error pulse
//   err_code      cause of the last error, held until the next one
module plug_pair_writer
    import enigma_pkg::*;
#(
    parameter int unsigned MAX_PAIRS = DEFAULT_MAX_PAIRS,
    parameter int unsigned LETTERS   = NUM_LETTERS
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [LETTERS-1:0] letter_in,
    input  logic               letter_valid,
    input  logic               clear,
    plug_pair_writer_if.master wr,
    output logic               table_clear,
    output logic [LETTERS-1:0] used,
    output logic [3:0]         pair_count,
    output logic               busy,
    output logic               err,
    output logic [1:0]         err_code
);

    state_e             state_q, state_d;
    logic [LETTERS-1:0] a_q, a_d;
    logic [LETTERS-1:0] b_q, b_d;
    logic [LETTERS-1:0] used_q, used_d;
    logic [3:0]         count_q, count_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               clear_pend_q, clear_pend_d;

    logic               letter_onehot;
    logic               letter_used;
    logic               table_full;
    logic               wr_valid_int;
    logic               handshake;

    onehot_check #(
        .WIDTH (LETTERS)
    ) u_onehot_check (
        .vec_i    (letter_in),
        .onehot_o (letter_onehot)
    );

    assign letter_used  = |(letter_in & used_q);
    assign table_full   = (count_q == 4'(MAX_PAIRS));
    assign wr_valid_int = (state_q == StWrite) || (state_q == StWriteRev);
    assign handshake    = wr_valid_int && wr.wr_ready;

    // State register
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            a_q          <= '0;
            b_q          <= '0;
            used_q       <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
            clear_pend_q <= 1'b0;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            used_q       <= used_d;
            count_q      <= count_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            clear_pend_q <= clear_pend_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        used_d       = used_q;
        count_d      = count_q;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        clear_pend_d = clear_pend_q;

        unique case (state_q)
            StIdle: begin
                // A clear deferred from a write is taken here, ahead of any new letter.
                if (clear || clear_pend_q) begin
                    state_d = StClear;
                end else if (letter_valid) begin
                    if (!letter_onehot) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ONEHOT;
                    end else if (letter_used) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_USED;
                    end else if (table_full) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_FULL;
                    end else begin
                        a_d     = letter_in;
                        state_d = StHold;
                    end
                end
            end

            StHold: begin
                if (clear) begin
                    state_d = StClear;
                end else if (letter_valid) begin
                    if (!letter_onehot) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ONEHOT;
                    end else if (letter_in == a_q) begin
                        // Repeating the first letter cancels the pair.
                        err_d      = 1'b1;
                        err_code_d = ERR_SELF;
                        a_d        = '0;
                        state_d    = StIdle;
                    end else if (letter_used) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_USED;
                    end else begin
                        b_d     = letter_in;
                        state_d = StWrite;
                    end
                end
            end

            StWrite: begin
                // A clear never aborts a handshake; remember it for after the commit.
                clear_pend_d = clear_pend_q | clear;
                if (handshake) begin
`ifdef PLUG_RECIPROCAL_EN
                    state_d = StWriteRev;
`else
                    used_d  = used_q | a_q | b_q;
                    count_d = count_q + 4'd1;
                    a_d     = '0;
                    b_d     = '0;
                    state_d = StIdle;
`endif
                end
            end

            StWriteRev: begin
`ifdef PLUG_RECIPROCAL_EN
                clear_pend_d = clear_pend_q | clear;
                if (handshake) begin
                    used_d  = used_q | a_q | b_q;
                    count_d = count_q + 4'd1;
                    a_d     = '0;
                    b_d     = '0;
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end

            StClear: begin
                used_d       = '0;
                count_d      = '0;
                a_d          = '0;
                b_d          = '0;
                clear_pend_d = 1'b0;
                state_d      = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        wr.wr_valid = wr_valid_int;
        wr.wr_a     = '0;
        wr.wr_b     = '0;
        if (state_q == StWrite) begin
            wr.wr_a = a_q;
            wr.wr_b = b_q;
        end else if (state_q == StWriteRev) begin
            wr.wr_a = b_q;
            wr.wr_b = a_q;
        end
        table_clear = (state_q == StClear);
        busy        = (state_q != StIdle);
        used        = used_q;
        pair_count  = count_q;
        err         = err_q;
        err_code    = err_code_q;
    end

endmodule
